// File: rtl/rx_word_packer_fanout_if.sv
// Receive byte stream in, per-channel packed word stream out, for rx_word_packer_fanout.
// The DUT binds the slave modport; the byte source / word sink binds master.
interface rx_word_packer_fanout_if #(
  parameter int pBYTES  = 4,
  parameter int pNUM_CH = 4
);
  localparam int EW = $clog2(pBYTES);

  logic                        i_rx_dv;
  logic                        i_rx_er;
  logic [7:0]                  i_rx_d;
  logic                        i_dst_valid;
  logic [pNUM_CH-1:0]          i_dst_mask;
  logic [pNUM_CH*pBYTES*8-1:0] o_data;
  logic [pNUM_CH-1:0]          o_valid;
  logic [pNUM_CH-1:0]          o_sop;
  logic [pNUM_CH-1:0]          o_eop;
  logic [pNUM_CH*EW-1:0]       o_empty;
  logic [pNUM_CH-1:0]          o_delete;

  modport master (
    output i_rx_dv, i_rx_er, i_rx_d, i_dst_valid, i_dst_mask,
    input  o_data, o_valid, o_sop, o_eop, o_empty, o_delete
  );

  modport slave (
    input  i_rx_dv, i_rx_er, i_rx_d, i_dst_valid, i_dst_mask,
    output o_data, o_valid, o_sop, o_eop, o_empty, o_delete
  );
endinterface

// File: rtl/rx_word_packer_fanout.sv
// Packs GMII receive bytes into pBYTES-wide words and fans them out to pNUM_CH channels,
// retracting started frames with o_delete. Define RUNT_DROP_EN to retract frames under 64 bytes.
//
// state | meaning
// IDLE  | waiting for a clean first byte (only after i_rx_dv has been seen low)
// PACK  | collecting bytes, releasing each full word when the next byte arrives
// DROP  | frame abandoned; swallow bytes until i_rx_dv falls
module rx_word_packer_fanout #(
  parameter int pBYTES     = 4,
  parameter int pNUM_CH    = 4,
  parameter int pSRC_PORT  = 0,
  parameter int pMAX_BYTES = 1522
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  rx_word_packer_fanout_if.slave bus
);

  localparam int WW = pBYTES * 8;
  localparam int EW = $clog2(pBYTES);
  localparam int LW = $clog2(pBYTES);
  localparam int CW = $clog2(pMAX_BYTES + 1) + 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(pMAX_BYTES);
  localparam logic [LW-1:0] LAST_LANE = LW'(pBYTES - 1);
`ifdef RUNT_DROP_EN
  localparam logic [CW-1:0] RUNT_LEN = CW'(64);
`endif

  function automatic logic [pNUM_CH-1:0] src_keep_f(input int src);
    logic [pNUM_CH-1:0] m;
    m = '1;
    for (int c = 0; c < pNUM_CH; c++) begin
      if (c == src) m[c] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [pNUM_CH-1:0] SRC_KEEP = src_keep_f(pSRC_PORT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [WW-1:0]        acc_q, acc_d;
  logic [WW-1:0]        stage_q, stage_d;
  logic                 stage_vld_q, stage_vld_d;
  logic [pNUM_CH-1:0]   active_q, active_d;
  logic [pNUM_CH-1:0]   started_q, started_d;
  logic                 sop_pend_q, sop_pend_d;
  logic                 dv_low_seen_q, dv_low_seen_d;

  logic [pNUM_CH*WW-1:0] data_q, data_d;
  logic [pNUM_CH*EW-1:0] empty_q, empty_d;
  logic [pNUM_CH-1:0]    valid_q, valid_d;
  logic [pNUM_CH-1:0]    sop_q, sop_d;
  logic [pNUM_CH-1:0]    eop_q, eop_d;
  logic [pNUM_CH-1:0]    delete_q, delete_d;

  logic [WW-1:0]        byte_word;
  logic [WW-1:0]        rel_word;
  logic [EW-1:0]        rel_empty;
  logic                 rel_en;
  logic                 rel_eop;
  logic                 runt;
  logic [pNUM_CH-1:0]   mask_now;
  logic [pNUM_CH-1:0]   rel_mask;
  logic [pNUM_CH-1:0]   del_mask;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lane_d        = lane_q;
    acc_d         = acc_q;
    stage_d       = stage_q;
    stage_vld_d   = stage_vld_q;
    active_d      = active_q;
    started_d     = started_q;
    sop_pend_d    = sop_pend_q;
    dv_low_seen_d = dv_low_seen_q | ~bus.i_rx_dv;
    rel_en        = 1'b0;
    rel_eop       = 1'b0;
    rel_word      = '0;
    rel_empty     = '0;
    mask_now      = active_q;
    del_mask      = '0;
    runt          = 1'b0;
`ifdef RUNT_DROP_EN
    runt = (cnt_q < RUNT_LEN);
`endif

    // Current byte merged into the word under construction; a fresh word starts zero-filled.
    byte_word = (lane_q == '0) ? '0 : acc_q;
    byte_word[(pBYTES - 1 - int'(lane_q)) * 8 +: 8] = bus.i_rx_d;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_rx_dv && dv_low_seen_q) begin
          if (bus.i_rx_er) begin
            state_d = ST_DROP;
          end else begin
            state_d     = ST_PACK;
            cnt_d       = CW'(1);
            acc_d       = byte_word;
            lane_d      = LW'(1);
            stage_vld_d = 1'b0;
            active_d    = SRC_KEEP;
            started_d   = '0;
            sop_pend_d  = 1'b1;
          end
        end
      end

      ST_PACK: begin
        if (!bus.i_rx_dv) begin
          state_d     = ST_IDLE;
          stage_vld_d = 1'b0;
          lane_d      = '0;
          if (runt) begin
            del_mask = active_q & started_q;
          end else begin
            rel_en  = 1'b1;
            rel_eop = 1'b1;
            if (stage_vld_q) begin
              rel_word  = stage_q;
              rel_empty = '0;
            end else begin
              rel_word  = acc_q;
              rel_empty = EW'(pBYTES - int'(lane_q));
            end
          end
        end else if (bus.i_rx_er || (cnt_q >= MAX_CNT)) begin
          // Error beats a same-cycle lookup: retract with the mask as it stood.
          state_d     = ST_DROP;
          del_mask    = active_q & started_q;
          stage_vld_d = 1'b0;
          lane_d      = '0;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (bus.i_dst_valid) begin
            mask_now = active_q & bus.i_dst_mask & SRC_KEEP;
            del_mask = active_q & ~mask_now & started_q;
            active_d = mask_now;
          end
          if (stage_vld_q) begin
            rel_en      = 1'b1;
            rel_word    = stage_q;
            stage_vld_d = 1'b0;
          end
          if (lane_q == LAST_LANE) begin
            stage_d     = byte_word;
            stage_vld_d = 1'b1;
            lane_d      = '0;
          end else begin
            acc_d  = byte_word;
            lane_d = lane_q + 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (!bus.i_rx_dv) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rel_mask = rel_en ? mask_now : '0;
    if (rel_en) begin
      sop_pend_d = 1'b0;
      if (sop_pend_q) started_d = rel_mask;
    end

    valid_d  = rel_mask;
    sop_d    = sop_pend_q ? rel_mask : '0;
    eop_d    = rel_eop ? rel_mask : '0;
    delete_d = del_mask;
    data_d   = data_q;
    empty_d  = empty_q;
    for (int c = 0; c < pNUM_CH; c++) begin
      if (rel_mask[c]) begin
        data_d[c*WW +: WW]  = rel_word;
        empty_d[c*EW +: EW] = rel_empty;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lane_q        <= '0;
      acc_q         <= '0;
      stage_q       <= '0;
      stage_vld_q   <= 1'b0;
      active_q      <= '0;
      started_q     <= '0;
      sop_pend_q    <= 1'b0;
      dv_low_seen_q <= 1'b0;
      data_q        <= '0;
      empty_q       <= '0;
      valid_q       <= '0;
      sop_q         <= '0;
      eop_q         <= '0;
      delete_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lane_q        <= lane_d;
      acc_q         <= acc_d;
      stage_q       <= stage_d;
      stage_vld_q   <= stage_vld_d;
      active_q      <= active_d;
      started_q     <= started_d;
      sop_pend_q    <= sop_pend_d;
      dv_low_seen_q <= dv_low_seen_d;
      data_q        <= data_d;
      empty_q       <= empty_d;
      valid_q       <= valid_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      delete_q      <= delete_d;
    end
  end

  assign bus.o_data   = data_q;
  assign bus.o_empty  = empty_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_sop    = sop_q;
  assign bus.o_eop    = eop_q;
  assign bus.o_delete = delete_q;

endmodule

// File: tb/tb_rx_word_packer_fanout.sv
// Bench for rx_word_packer_fanout: directed frames plus random frames, each compared per
// channel against a byte-index reference model of the expected word/delete events.
module tb_rx_word_packer_fanout;

  localparam int NB   = 4;
  localparam int NC   = 4;
  localparam int SRC  = 0;
  localparam int MAXB = 1522;
  localparam logic [NC-1:0] KEEP = 4'b1110;
`ifdef RUNT_DROP_EN
  localparam bit RUNT = 1'b1;
`else
  localparam bit RUNT = 1'b0;
`endif

  typedef struct packed {
    int          cyc;
    logic        kind;   // 0 word, 1 delete
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   last_p     = 0;

  ev_t        exp_q [NC][$];
  ev_t        act_q [NC][$];
  logic [7:0] fb [1:2048];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_word_packer_fanout_if #(.pBYTES(NB), .pNUM_CH(NC)) bus ();

  rx_word_packer_fanout #(
    .pBYTES(NB), .pNUM_CH(NC), .pSRC_PORT(SRC), .pMAX_BYTES(MAXB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      for (int c = 0; c < NC; c++) begin
        if (bus.o_delete[c]) begin
          ev = '0;
          ev.cyc = cyc; ev.kind = 1'b1;
          act_q[c].push_back(ev);
        end
        if (bus.o_valid[c]) begin
          ev = '0;
          ev.cyc   = cyc;
          ev.data  = bus.o_data[c*32 +: 32];
          ev.sop   = bus.o_sop[c];
          ev.eop   = bus.o_eop[c];
          ev.empty = bus.o_eop[c] ? bus.o_empty[c*2 +: 2] : 2'd0;
          act_q[c].push_back(ev);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [NC-1:0] m, input int cy, input logic kind,
                         input logic [31:0] d, input logic s, input logic eo, input logic [1:0] em);
    ev_t ev;
    ev.cyc = cy; ev.kind = kind; ev.data = d; ev.sop = s; ev.eop = eo; ev.empty = em;
    for (int c = 0; c < NC; c++) if (m[c]) exp_q[c].push_back(ev);
  endtask

  // Reference: walk the frame byte by byte. Byte j is sampled at cycle p+j; word k (bytes
  // 4k-3..4k) leaves when byte 4k+1 arrives; the last word leaves one cycle after the last byte.
  task automatic model_frame(input int p, input int len, input int e, input int l1,
                             input logic [NC-1:0] m1, input int l2, input logic [NC-1:0] m2);
    logic [NC-1:0] mask, nm, started;
    logic [31:0]   w;
    bit            sop_done, dropped;
    int            k, n;
    mask = KEEP; started = '0; sop_done = 0; dropped = 0;
    for (int j = 1; j <= len; j++) begin
      if (j == e || j > MAXB) begin
        if (sop_done) push_ev(mask & started, p + j, 1'b1, 32'd0, 1'b0, 1'b0, 2'd0);
        dropped = 1;
        break;
      end
      if (j == l1 || j == l2) begin
        nm = mask & ((j == l1) ? m1 : m2) & KEEP;
        if (sop_done) push_ev(mask & ~nm & started, p + j, 1'b1, 32'd0, 1'b0, 1'b0, 2'd0);
        mask = nm;
      end
      if (j > 1 && ((j - 1) % 4) == 0) begin
        k = (j - 1) / 4;
        w = {fb[4*k-3], fb[4*k-2], fb[4*k-1], fb[4*k]};
        push_ev(mask, p + j, 1'b0, w, !sop_done, 1'b0, 2'd0);
        if (!sop_done) begin started = mask; sop_done = 1; end
      end
    end
    if (!dropped) begin
      if (RUNT && len < 64) begin
        push_ev(mask & started, p + len + 1, 1'b1, 32'd0, 1'b0, 1'b0, 2'd0);
      end else begin
        n = len - 4 * ((len - 1) / 4);
        w = '0;
        for (int i = 0; i < n; i++) w[31-8*i -: 8] = fb[len-n+1+i];
        push_ev(mask, p + len + 1, 1'b0, w, !sop_done, 1'b1, 2'(4 - n));
      end
    end
  endtask

  task automatic send_frame(input int len, input int e, input int l1, input logic [NC-1:0] m1,
                            input int l2, input logic [NC-1:0] m2, input int gap);
    @(posedge clk); #1;
    last_p = cyc;
    model_frame(cyc, len, e, l1, m1, l2, m2);
    for (int j = 1; j <= len; j++) begin
      bus.i_rx_dv     = 1'b1;
      bus.i_rx_d      = fb[j];
      bus.i_rx_er     = (j == e);
      bus.i_dst_valid = (j == l1) || (j == l2);
      bus.i_dst_mask  = (j == l2) ? m2 : m1;
      @(posedge clk); #1;
    end
    bus.i_rx_dv = 1'b0; bus.i_rx_er = 1'b0; bus.i_rx_d = 8'd0; bus.i_dst_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      // Lookup pulses between frames must be ignored.
      bus.i_dst_valid = ($urandom_range(0, 3) == 0);
      bus.i_dst_mask  = 4'($urandom);
      @(posedge clk); #1;
    end
    bus.i_dst_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_events();
    int n;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("count_ch%0d", c), 128'(act_q[c].size()), 128'(exp_q[c].size()));
      n = (act_q[c].size() < exp_q[c].size()) ? act_q[c].size() : exp_q[c].size();
      for (int i = 0; i < n; i++)
        chk($sformatf("event_ch%0d_%0d", c, i), 128'(act_q[c][i]), 128'(exp_q[c][i]));
    end
  endtask

  task automatic clear_events();
    for (int c = 0; c < NC; c++) begin
      act_q[c].delete();
      exp_q[c].delete();
    end
  endtask

  task automatic fill_inc(input int len);
    for (int j = 1; j <= len; j++) fb[j] = 8'(j);
  endtask

  task automatic fill_rand(input int len);
    for (int j = 1; j <= len; j++) fb[j] = 8'($urandom);
  endtask

  initial begin
    int len, e, l1, l2;
    int short_len [6] = '{1, 2, 3, 4, 5, 8};
    logic [NC-1:0] m1, m2;

    bus.i_rx_dv = 1'b0; bus.i_rx_er = 1'b0; bus.i_rx_d = 8'd0;
    bus.i_dst_valid = 1'b0; bus.i_dst_mask = '0;

    repeat (3) @(negedge clk);
    chk("reset_data", 128'(bus.o_data), 128'(0));
    chk("reset_ctl", 128'({bus.o_valid, bus.o_sop, bus.o_eop, bus.o_delete, bus.o_empty}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 70-byte counting frame, broadcast
    fill_inc(70);
    send_frame(70, 0, 0, '0, 0, '0, 2);
    settle();
    chk("t1_ch1_words", 128'(act_q[1].size()), 128'(18));
    chk("t1_ch0_silent", 128'(act_q[0].size()), 128'(0));
    if (act_q[1].size() == 18) begin
      chk("t1_first", 128'({act_q[1][0].data, act_q[1][0].sop}), 128'({32'h01020304, 1'b1}));
      chk("t1_last", 128'({act_q[1][17].data, act_q[1][17].eop, act_q[1][17].empty}),
          128'({32'h45460000, 1'b1, 2'd2}));
    end
    check_events();
    clear_events();

    // Same frame, lookup to channel 2 on byte 10
    fill_inc(70);
    send_frame(70, 0, 10, 4'b0100, 0, '0, 2);
    settle();
    chk("t2_ch1_len", 128'(act_q[1].size()), 128'(3));
    chk("t2_ch3_len", 128'(act_q[3].size()), 128'(3));
    chk("t2_ch2_len", 128'(act_q[2].size()), 128'(18));
    if (act_q[1].size() == 3)
      chk("t2_ch1_del", 128'({act_q[1][2].kind, act_q[1][2].cyc}), 128'({1'b1, last_p + 10}));
    check_events();
    clear_events();

    // Error on byte 30 of 68, then a clean 64-byte frame
    fill_rand(68);
    send_frame(68, 30, 0, '0, 0, '0, 2);
    settle();
    chk("t3_ch2_len", 128'(act_q[2].size()), 128'(8));
    if (act_q[2].size() == 8) chk("t3_ch2_del", 128'(act_q[2][7].kind), 128'(1));
    check_events();
    clear_events();
    fill_rand(64);
    send_frame(64, 0, 0, '0, 0, '0, 2);
    settle();
    chk("t3b_ch2_len", 128'(act_q[2].size()), 128'(16));
    if (act_q[2].size() == 16)
      chk("t3b_last", 128'({act_q[2][15].eop, act_q[2][15].empty}), 128'({1'b1, 2'd0}));
    check_events();
    clear_events();

    // Overlength
    fill_rand(1600);
    send_frame(1600, 0, 0, '0, 0, '0, 2);
    settle();
    chk("t4_ch3_len", 128'(act_q[3].size()), 128'(381));
    if (act_q[3].size() == 381)
      chk("t4_del", 128'({act_q[3][380].kind, act_q[3][380].cyc}), 128'({1'b1, last_p + 1523}));
    check_events();
    clear_events();

    // 40-byte runt
    fill_rand(40);
    send_frame(40, 0, 0, '0, 0, '0, 2);
    settle();
    chk("t5_ch1_len", 128'(act_q[1].size()), 128'(10));
    if (act_q[1].size() == 10)
      chk("t5_tail", 128'({act_q[1][9].kind, act_q[1][9].eop}), 128'({RUNT, !RUNT}));
    check_events();
    clear_events();

    // Reset in the middle of a frame; i_rx_dv stays high through and after reset
    fill_rand(40);
    @(posedge clk); #1;
    for (int j = 1; j <= 40; j++) begin
      bus.i_rx_dv = 1'b1; bus.i_rx_d = fb[j]; bus.i_rx_er = 1'b0; bus.i_dst_valid = 1'b0;
      if (j == 20) rst_n = 1'b0;
      if (j == 23) rst_n = 1'b1;
      if (j == 24) clear_events();
      @(negedge clk);
      if (j == 21) begin
        chk("rstmid_data", 128'(bus.o_data), 128'(0));
        chk("rstmid_ctl", 128'({bus.o_valid, bus.o_sop, bus.o_eop, bus.o_delete, bus.o_empty}), 128'(0));
      end
      @(posedge clk); #1;
    end
    bus.i_rx_dv = 1'b0;
    settle();
    for (int c = 0; c < NC; c++) chk($sformatf("rstmid_quiet_ch%0d", c), 128'(act_q[c].size()), 128'(0));
    clear_events();
    fill_rand(64);
    send_frame(64, 0, 0, '0, 0, '0, 2);
    settle();
    chk("t6_ch1_len", 128'(act_q[1].size()), 128'(16));
    check_events();
    clear_events();

    // Random frames: short lengths first, then random length/error/lookups, tight gaps
    for (int f = 0; f < 30; f++) begin
      len = (f < 6) ? short_len[f] : $urandom_range(1, 150);
      e   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      l1  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : 0;
      m1  = 4'($urandom);
      l2  = (l1 != 0 && l1 < len && $urandom_range(0, 1) == 1) ? $urandom_range(l1 + 1, len) : 0;
      m2  = 4'($urandom);
      fill_rand(len);
      send_frame(len, e, l1, m1, l2, m2, $urandom_range(0, 2));
      settle();
      check_events();
      clear_events();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
